// File: rtl/am_eval_pkg.sv
`default_nettype none
// ============================================================================
// Module      : am_eval_pkg
// Description : Shared definitions for approximate-multiplier evaluation
//               monitors: default widths, window FSM state encoding and the
//               accumulator width helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package am_eval_pkg;

    localparam int c_w_default       = 8;
    localparam int c_cnt_w_default   = 17;
    localparam int c_samples_default = 65536;

    // Sum of |error| over up to 2^cnt_w-1 samples, each below 2^(2w).
    function automatic int calc_sum_w(input int w, input int cnt_w);
        return 2 * w + cnt_w;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage : am_eval_pkg
`default_nettype wire

// File: rtl/am_ed_calc.sv
`default_nettype none
// ============================================================================
// Module      : am_ed_calc
// Description : Combinational error-distance calculator. Recomputes the exact
//               product of two unsigned operands and compares it against an
//               approximate product.
// Ports       : i_x, i_y  - W-bit unsigned operands
//               i_z       - 2W-bit approximate product
//               o_p       - exact product x*y (2W bits)
//               o_d       - signed error z - p (2W+1 bits)
//               o_ed      - error distance |z - p| (2W bits)
// Revision    : 1.0 - initial release
// ============================================================================
module am_ed_calc #(
    parameter int W = 8
) (
    input  logic [W-1:0]          i_x,
    input  logic [W-1:0]          i_y,
    input  logic [2*W-1:0]        i_z,
    output logic [2*W-1:0]        o_p,
    output logic signed [2*W:0]   o_d,
    output logic [2*W-1:0]        o_ed
);

    logic [2*W-1:0] w_p;

    always_comb begin
        w_p  = {{W{1'b0}}, i_x} * {{W{1'b0}}, i_y};
        o_p  = w_p;
        o_d  = $signed({1'b0, i_z}) - $signed({1'b0, w_p});
        // Magnitude taken by ordered subtraction so it stays 2W bits wide.
        o_ed = (i_z >= w_p) ? (i_z - w_p) : (w_p - i_z);
    end

endmodule : am_ed_calc
`default_nettype wire

// File: rtl/am_error_monitor.sv
`default_nettype none
// ============================================================================
// Module      : am_error_monitor
// Description : Streaming error-statistics accumulator for an approximate
//               unsigned WxW multiplier. Collects error count, sum of error
//               distance, signed error sum and maximum error distance (with
//               the operands that first produced it) over a window of
//               SAMPLES accepted operand pairs.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               start               - clear and begin a window (IDLE/DONE only)
//               in_valid/in_ready   - sample handshake
//               x, y, z             - operands and approximate product
//               busy                - high while collecting or draining
//               done                - one-cycle pulse when results are final
//               sample_cnt, err_cnt - samples accumulated / erroneous samples
//               sum_ed, sum_sed     - sum of |z-xy|, signed sum of (z-xy)
//               max_ed, max_x, max_y- largest |z-xy| and its first operands
// Revision    : 1.0 - initial release
// ============================================================================
module am_error_monitor
    import am_eval_pkg::*;
#(
    parameter int W       = c_w_default,
    parameter int SAMPLES = c_samples_default,
    parameter int CNT_W   = c_cnt_w_default,
    parameter int SUM_W   = calc_sum_w(W, CNT_W)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [W-1:0]          x,
    input  logic [W-1:0]          y,
    input  logic [2*W-1:0]        z,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      sample_cnt,
    output logic [CNT_W-1:0]      err_cnt,
    output logic [SUM_W-1:0]      sum_ed,
    output logic signed [SUM_W:0] sum_sed,
    output logic [2*W-1:0]        max_ed,
    output logic [W-1:0]          max_x,
    output logic [W-1:0]          max_y
);

    localparam logic [CNT_W-1:0] c_last    = CNT_W'(SAMPLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    state_t r_state;
    state_t w_state_next;

    logic [CNT_W-1:0] r_acc_cnt;
    logic             r_in_ready;
    logic             r_busy;
    logic             r_done;

    // Stage 1: captured sample
    logic             r_s1_valid;
    logic [W-1:0]     r_s1_x;
    logic [W-1:0]     r_s1_y;
    logic [2*W-1:0]   r_s1_z;

    // Stage 2: evaluated sample
    logic             r_s2_valid;
    logic [W-1:0]     r_s2_x;
    logic [W-1:0]     r_s2_y;
    logic signed [2*W:0] r_s2_d;
    logic [2*W-1:0]   r_s2_ed;
    logic             r_s2_err;

    // Accumulators
    logic [CNT_W-1:0]      r_sample_cnt;
    logic [CNT_W-1:0]      r_err_cnt;
    logic [SUM_W-1:0]      r_sum_ed;
    logic signed [SUM_W:0] r_sum_sed;
    logic [2*W-1:0]        r_max_ed;
    logic [W-1:0]          r_max_x;
    logic [W-1:0]          r_max_y;

    logic             w_start_ok;
    logic             w_accept;
    logic             w_last_accept;
    logic             w_pipe_empty;
    logic [2*W-1:0]   w_p;
    logic signed [2*W:0] w_d;
    logic [2*W-1:0]   w_ed;

    assign w_start_ok    = start && ((r_state == IDLE) || (r_state == DONE));
    // in_ready is only ever high in RUN, so accepts happen only there.
    assign w_accept      = in_valid && r_in_ready;
    assign w_last_accept = w_accept && (r_acc_cnt == c_last);
    assign w_pipe_empty  = !r_s1_valid && !r_s2_valid;

    // ------------------------------------------------------------------
    // Window FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start)         w_state_next = RUN;
            RUN:     if (w_last_accept) w_state_next = DRAIN;
            DRAIN:   if (w_pipe_empty)  w_state_next = DONE;
            DONE:    if (start)         w_state_next = RUN;
            default:                    w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake, status flags and accepted-sample counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_cnt  <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_acc_cnt  <= '0;
                r_in_ready <= 1'b1;
            end else if (w_accept) begin
                r_acc_cnt <= r_acc_cnt + c_cnt_one;
                if (w_last_accept) begin
                    r_in_ready <= 1'b0;
                end
            end
            r_busy <= (w_state_next == RUN) || (w_state_next == DRAIN);
            r_done <= (w_state_next == DONE) && (r_state != DONE);
        end
    end

    // ------------------------------------------------------------------
    // Two-stage sample pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            r_s2_valid <= r_s1_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s1_x <= x;
            r_s1_y <= y;
            r_s1_z <= z;
        end
        if (r_s1_valid) begin
            r_s2_x   <= r_s1_x;
            r_s2_y   <= r_s1_y;
            r_s2_d   <= w_d;
            r_s2_ed  <= w_ed;
            r_s2_err <= (r_s1_z != w_p);
        end
    end

    am_ed_calc #(
        .W (W)
    ) u_ed_calc (
        .i_x  (r_s1_x),
        .i_y  (r_s1_y),
        .i_z  (r_s1_z),
        .o_p  (w_p),
        .o_d  (w_d),
        .o_ed (w_ed)
    );

    // ------------------------------------------------------------------
    // Accumulators
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || w_start_ok) begin
            r_sample_cnt <= '0;
            r_err_cnt    <= '0;
            r_sum_ed     <= '0;
            r_sum_sed    <= '0;
            r_max_ed     <= '0;
            r_max_x      <= '0;
            r_max_y      <= '0;
        end else if (r_s2_valid) begin
            r_sample_cnt <= r_sample_cnt + c_cnt_one;
            r_err_cnt    <= r_err_cnt + {{(CNT_W-1){1'b0}}, r_s2_err};
            r_sum_ed     <= r_sum_ed + {{(SUM_W-2*W){1'b0}}, r_s2_ed};
            r_sum_sed    <= r_sum_sed + {{(SUM_W-2*W){r_s2_d[2*W]}}, r_s2_d};
            // Strictly greater: ties keep the earliest sample's operands.
            if (r_s2_ed > r_max_ed) begin
                r_max_ed <= r_s2_ed;
                r_max_x  <= r_s2_x;
                r_max_y  <= r_s2_y;
            end
        end
    end

    assign in_ready   = r_in_ready;
    assign busy       = r_busy;
    assign done       = r_done;
    assign sample_cnt = r_sample_cnt;
    assign err_cnt    = r_err_cnt;
    assign sum_ed     = r_sum_ed;
    assign sum_sed    = r_sum_sed;
    assign max_ed     = r_max_ed;
    assign max_x      = r_max_x;
    assign max_y      = r_max_y;

endmodule : am_error_monitor
`default_nettype wire

// File: tb/tb_am_error_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_am_error_monitor
// Description : Self-checking bench for am_error_monitor. Four instances with
//               window sizes 4, 3, 8 and 65536 are driven from a table of
//               windows with hand-computed results, plus directed sequences
//               for backpressure, reset mid-window and the exhaustive sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_am_error_monitor;

    localparam int c_n_dut = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_s      [c_n_dut];
    logic        start_s    [c_n_dut];
    logic        in_valid_s [c_n_dut];
    logic        in_ready_s [c_n_dut];
    logic [7:0]  x_s        [c_n_dut];
    logic [7:0]  y_s        [c_n_dut];
    logic [15:0] z_s        [c_n_dut];
    logic        busy_s     [c_n_dut];
    logic        done_s     [c_n_dut];
    logic [16:0] cnt_s      [c_n_dut];
    logic [16:0] err_s      [c_n_dut];
    logic [32:0] sum_ed_s   [c_n_dut];
    logic signed [33:0] sum_sed_s [c_n_dut];
    logic [15:0] max_ed_s   [c_n_dut];
    logic [7:0]  max_x_s    [c_n_dut];
    logic [7:0]  max_y_s    [c_n_dut];

    for (genvar g = 0; g < c_n_dut; g++) begin : g_dut
        localparam int c_samp = (g == 0) ? 4 : (g == 1) ? 3 : (g == 2) ? 8 : 65536;
        am_error_monitor #(
            .W       (8),
            .SAMPLES (c_samp),
            .CNT_W   (17)
        ) u_dut (
            .clk        (clk),
            .rst        (rst_s[g]),
            .start      (start_s[g]),
            .in_valid   (in_valid_s[g]),
            .in_ready   (in_ready_s[g]),
            .x          (x_s[g]),
            .y          (y_s[g]),
            .z          (z_s[g]),
            .busy       (busy_s[g]),
            .done       (done_s[g]),
            .sample_cnt (cnt_s[g]),
            .err_cnt    (err_s[g]),
            .sum_ed     (sum_ed_s[g]),
            .sum_sed    (sum_sed_s[g]),
            .max_ed     (max_ed_s[g]),
            .max_x      (max_x_s[g]),
            .max_y      (max_y_s[g])
        );
    end

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] z;
    } smp_t;

    typedef struct {
        string       name;
        int          inst;
        int          first;
        int          n;
        logic [16:0] cnt;
        logic [16:0] err;
        logic [32:0] sum_ed;
        longint      sum_sed;
        logic [15:0] max_ed;
        logic [7:0]  max_x;
        logic [7:0]  max_y;
    } win_t;

    smp_t smp[$];
    win_t win[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    function automatic void add_smp(input int xv, input int yv, input int zv);
        smp_t s;
        s.x = 8'(xv);
        s.y = 8'(yv);
        s.z = 16'(zv);
        smp.push_back(s);
    endfunction

    function automatic void add_win(input string nm, input int inst, input int n,
                                    input int cnt, input int err, input int sed,
                                    input longint ssed, input int med,
                                    input int mx, input int my);
        win_t w;
        w.name    = nm;
        w.inst    = inst;
        w.n       = n;
        w.first   = smp.size() - n;
        w.cnt     = 17'(cnt);
        w.err     = 17'(err);
        w.sum_ed  = 33'(sed);
        w.sum_sed = ssed;
        w.max_ed  = 16'(med);
        w.max_x   = 8'(mx);
        w.max_y   = 8'(my);
        win.push_back(w);
    endfunction

    task automatic check_zero(input int i, input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready_s[i]), 64'd0);
        chk({tag, "_busy"},     64'(busy_s[i]),     64'd0);
        chk({tag, "_done"},     64'(done_s[i]),     64'd0);
        chk({tag, "_cnt"},      64'(cnt_s[i]),      64'd0);
        chk({tag, "_err"},      64'(err_s[i]),      64'd0);
        chk({tag, "_sum_ed"},   64'(sum_ed_s[i]),   64'd0);
        chk({tag, "_sum_sed"},  64'(sum_sed_s[i]),  64'd0);
        chk({tag, "_max_ed"},   64'(max_ed_s[i]),   64'd0);
        chk({tag, "_max_x"},    64'(max_x_s[i]),    64'd0);
        chk({tag, "_max_y"},    64'(max_y_s[i]),    64'd0);
    endtask

    task automatic pulse_start(input int i);
        start_s[i] = 1'b1;
        @(negedge clk);
        start_s[i] = 1'b0;
    endtask

    // Wait for the done pulse, then confirm it lasted exactly one cycle.
    task automatic wait_done(input int i, input string tag);
        int cyc = 0;
        while (done_s[i] !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_done_seen"}, 64'(done_s[i]), 64'd1);
        @(negedge clk);
        chk({tag, "_done_width"}, 64'(done_s[i]), 64'd0);
        chk({tag, "_busy_after"}, 64'(busy_s[i]), 64'd0);
    endtask

    task automatic run_window(input int k);
        int i = win[k].inst;
        pulse_start(i);
        chk({win[k].name, "_busy"}, 64'(busy_s[i]), 64'd1);
        for (int j = 0; j < win[k].n; j++) begin
            in_valid_s[i] = 1'b1;
            x_s[i] = smp[win[k].first + j].x;
            y_s[i] = smp[win[k].first + j].y;
            z_s[i] = smp[win[k].first + j].z;
            chk({win[k].name, "_in_ready"}, 64'(in_ready_s[i]), 64'd1);
            @(negedge clk);
        end
        in_valid_s[i] = 1'b0;
        wait_done(i, win[k].name);
        chk({win[k].name, "_cnt"},     64'(cnt_s[i]),              64'(win[k].cnt));
        chk({win[k].name, "_err"},     64'(err_s[i]),              64'(win[k].err));
        chk({win[k].name, "_sum_ed"},  64'(sum_ed_s[i]),           64'(win[k].sum_ed));
        chk({win[k].name, "_sum_sed"}, 64'($signed(sum_sed_s[i])), 64'(win[k].sum_sed));
        chk({win[k].name, "_max_ed"},  64'(max_ed_s[i]),           64'(win[k].max_ed));
        chk({win[k].name, "_max_x"},   64'(max_x_s[i]),            64'(win[k].max_x));
        chk({win[k].name, "_max_y"},   64'(max_y_s[i]),            64'(win[k].max_y));
    endtask

    initial begin
        for (int i = 0; i < c_n_dut; i++) begin
            rst_s[i] = 1'b1; start_s[i] = 1'b0; in_valid_s[i] = 1'b0;
            x_s[i] = '0; y_s[i] = '0; z_s[i] = '0;
        end

        // Window table: samples first, then the window that consumes them.
        add_smp(1, 2, 2); add_smp(7, 9, 63); add_smp(255, 1, 255); add_smp(16, 16, 256);
        add_win("zero_err", 0, 4, 4, 0, 0, 0, 0, 0, 0);
        add_smp(255, 255, 64961); add_smp(3, 5, 15); add_smp(0, 7, 0); add_smp(10, 10, 90);
        add_win("mixed", 0, 4, 4, 2, 74, -74, 64, 255, 255);
        add_smp(10, 10, 101); add_smp(20, 3, 70); add_smp(255, 0, 5); add_smp(9, 9, 81);
        add_win("positive", 0, 4, 4, 3, 16, 16, 10, 20, 3);
        add_smp(2, 3, 16); add_smp(4, 4, 26); add_smp(1, 1, 1);
        add_win("max_tie", 1, 3, 3, 2, 20, 20, 10, 2, 3);
        add_smp(0, 0, 0); add_smp(1, 1, 1); add_smp(2, 3, 6); add_smp(5, 5, 25);
        add_smp(12, 12, 144); add_smp(100, 2, 200); add_smp(255, 255, 65025); add_smp(128, 2, 256);
        add_win("after_rst", 2, 8, 8, 0, 0, 0, 0, 0, 0);

        // Reset state, while asserted and after release.
        repeat (3) @(negedge clk);
        for (int i = 0; i < c_n_dut; i++) check_zero(i, "reset_held");
        for (int i = 0; i < c_n_dut; i++) rst_s[i] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < c_n_dut; i++) check_zero(i, "reset_rel");

        // Reset mid-window on the 8-sample instance discards partial results.
        pulse_start(2);
        for (int j = 0; j < 2; j++) begin
            in_valid_s[2] = 1'b1; x_s[2] = 8'(3 + j); y_s[2] = 8'(3 + j); z_s[2] = 16'd0;
            @(negedge clk);
        end
        in_valid_s[2] = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrun_cnt", 64'(cnt_s[2]), 64'd2);
        chk("midrun_sum_ed", 64'(sum_ed_s[2]), 64'd25);
        rst_s[2] = 1'b1;
        @(negedge clk);
        rst_s[2] = 1'b0;
        check_zero(2, "midrun_rst");
        @(negedge clk);
        check_zero(2, "midrun_idle");

        // Table-driven windows.
        for (int k = 0; k < win.size(); k++) run_window(k);

        // Backpressure with gaps: only the first four valid samples count.
        begin
            logic [7:0] pat;
            int m;
            pat = 8'b1110_1101; // bit p is in_valid in cycle p
            m   = 0;
            pulse_start(0);
            for (int p = 0; p < 8; p++) begin
                in_valid_s[0] = pat[p];
                x_s[0] = 8'(p + 1);
                y_s[0] = 8'd3;
                z_s[0] = (p < 6) ? 16'((p + 1) * 3) : 16'd0;
                chk("bp_in_ready", 64'(in_ready_s[0]), (m < 4) ? 64'd1 : 64'd0);
                if (pat[p] && m < 4) m++;
                @(negedge clk);
            end
            in_valid_s[0] = 1'b0;
            wait_done(0, "bp");
            chk("bp_cnt",    64'(cnt_s[0]),    64'd4);
            chk("bp_err",    64'(err_s[0]),    64'd0);
            chk("bp_sum_ed", 64'(sum_ed_s[0]), 64'd0);
            chk("bp_max_x",  64'(max_x_s[0]),  64'd0);
        end

        // Start during RUN must not clear the window in progress.
        pulse_start(1);
        for (int j = 0; j < 3; j++) begin
            in_valid_s[1] = 1'b1; x_s[1] = 8'd6; y_s[1] = 8'd7; z_s[1] = 16'd40;
            start_s[1] = (j == 2);
            @(negedge clk);
        end
        in_valid_s[1] = 1'b0;
        start_s[1]    = 1'b0;
        wait_done(1, "start_in_run");
        chk("start_in_run_cnt",     64'(cnt_s[1]),              64'd3);
        chk("start_in_run_sum_sed", 64'($signed(sum_sed_s[1])), 64'(-6));

        // Exhaustive sweep with a constant +1 error.
        pulse_start(3);
        for (int xv = 0; xv < 256; xv++) begin
            for (int yv = 0; yv < 256; yv++) begin
                in_valid_s[3] = 1'b1;
                x_s[3] = 8'(xv);
                y_s[3] = 8'(yv);
                z_s[3] = 16'(xv * yv + 1);
                @(negedge clk);
            end
        end
        in_valid_s[3] = 1'b0;
        chk("exh_in_ready_low", 64'(in_ready_s[3]), 64'd0);
        wait_done(3, "exh");
        chk("exh_cnt",     64'(cnt_s[3]),              64'd65536);
        chk("exh_err",     64'(err_s[3]),              64'd65536);
        chk("exh_sum_ed",  64'(sum_ed_s[3]),           64'd65536);
        chk("exh_sum_sed", 64'($signed(sum_sed_s[3])), 64'd65536);
        chk("exh_max_ed",  64'(max_ed_s[3]),           64'd1);
        chk("exh_max_x",   64'(max_x_s[3]),            64'd0);
        chk("exh_max_y",   64'(max_y_s[3]),            64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_am_error_monitor
`default_nettype wire
